// File: rtl/fll_cfg_slave.sv
// fll_cfg_slave
// FLL-side responder of the 4-phase cfgreq/cfgack configuration bus.
// Holds the FLL register file (status, CFG1, CFG2, INTEG) and drives the
// decoded FLL core controls straight from those registers.
// Build option: define FLL_CFG_REQ_SYNC_EN to pass cfgreq through a 2-flop
// synchronizer before the FSM (adds two edges of request/release latency).
module fll_cfg_slave #(
    parameter logic [31:0] CFG1_RST  = 32'h4088_0001,
    parameter logic [31:0] CFG2_RST  = 32'h0000_0F20,
    parameter logic [31:0] INTEG_RST = 32'h0000_0000
) (
    input  logic        ref_clk,
    input  logic        rst_n,
    input  logic        cfgreq,
    input  logic        cfgweb,
    input  logic [1:0]  cfgad,
    input  logic [31:0] cfgd,
    output logic        cfgack,
    output logic [31:0] cfgq,
    input  logic        fll_lock,
    input  logic [15:0] dco_cnt,
    output logic        mode,
    output logic        lock_en,
    output logic [3:0]  loop_gain,
    output logic [9:0]  dco_in,
    output logic [15:0] mul_factor,
    output logic [3:0]  lock_tol,
    output logic [7:0]  lock_cnt,
    output logic [3:0]  unlock_cnt,
    output logic [31:0] integ_val,
    output logic        cfg_update,
    output logic        integ_load
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        req_i;
    logic        cfgack_reg;
    logic [31:0] cfgq_reg;
    logic [31:0] cfg1_reg;
    logic [15:0] cfg2_reg;
    logic [31:0] integ_reg;
    logic        cfg_update_reg;
    logic        integ_load_reg;
    logic [31:0] rd_data;

`ifdef FLL_CFG_REQ_SYNC_EN
    logic [1:0] req_sync_reg;

    // Two-stage synchronizer for the request coming from the control FSM
    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            req_sync_reg <= 2'b00;
        end else begin
            req_sync_reg <= {req_sync_reg[0], cfgreq};
        end
    end

    assign req_i = req_sync_reg[1];
`else
    assign req_i = cfgreq;
`endif

    // Next-state logic: one ACCESS cycle, then hold ACK until request drops
    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:   state_next = req_i ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_next = ST_ACK;
            ST_ACK:    state_next = req_i ? ST_ACK : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register and registered acknowledge (rises on entry to ACK)
    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cfgack_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cfgack_reg <= (state_next == ST_ACK);
        end
    end

    // Read mux; status word reflects the core inputs live during ACCESS
    always_comb begin
        rd_data = 32'h0;
        case (cfgad)
            2'd0: rd_data = {fll_lock, 15'b0, dco_cnt};
            2'd1: rd_data = cfg1_reg;
            2'd2: rd_data = {16'b0, cfg2_reg};
            2'd3: rd_data = integ_reg;
            default: rd_data = 32'h0;
        endcase
    end

    // Register file commit, read capture and update strobes at end of ACCESS
    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            cfg1_reg       <= CFG1_RST;
            cfg2_reg       <= CFG2_RST[15:0];
            integ_reg      <= INTEG_RST;
            cfgq_reg       <= 32'h0;
            cfg_update_reg <= 1'b0;
            integ_load_reg <= 1'b0;
        end else begin
            cfg_update_reg <= 1'b0;
            integ_load_reg <= 1'b0;
            if (state_reg == ST_ACCESS) begin
                if (!cfgweb) begin
                    // Address 0 is the read-only status word: write is acked but dropped
                    case (cfgad)
                        2'd1: begin
                            cfg1_reg       <= cfgd;
                            cfg_update_reg <= 1'b1;
                        end
                        2'd2: begin
                            cfg2_reg       <= cfgd[15:0];
                            cfg_update_reg <= 1'b1;
                        end
                        2'd3: begin
                            integ_reg      <= cfgd;
                            integ_load_reg <= 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    cfgq_reg <= rd_data;
                end
            end
        end
    end

    assign cfgack     = cfgack_reg;
    assign cfgq       = cfgq_reg;
    assign mode       = cfg1_reg[31];
    assign lock_en    = cfg1_reg[30];
    assign loop_gain  = cfg1_reg[29:26];
    assign dco_in     = cfg1_reg[25:16];
    assign mul_factor = cfg1_reg[15:0];
    assign lock_tol   = cfg2_reg[15:12];
    assign lock_cnt   = cfg2_reg[11:4];
    assign unlock_cnt = cfg2_reg[3:0];
    assign integ_val  = integ_reg;
    assign cfg_update = cfg_update_reg;
    assign integ_load = integ_load_reg;

endmodule

// File: tb/tb_fll_cfg_slave.sv
// tb_fll_cfg_slave
// Directed bench for fll_cfg_slave. The driver pushes the hand-computed
// expected register/readback state for every access; a monitor pops it on
// each cfgack rise and compares. Honors FLL_CFG_REQ_SYNC_EN for latencies.
module tb_fll_cfg_slave;

`ifdef FLL_CFG_REQ_SYNC_EN
    localparam int LAT = 4;
    localparam int REL = 3;
`else
    localparam int LAT = 2;
    localparam int REL = 1;
`endif

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] cfg1;
        logic [15:0] cfg2;
        logic [31:0] integ;
        logic [1:0]  pulses;   // {cfg_update, integ_load} in first ACK cycle
    } exp_t;

    logic        ref_clk;
    logic        rst_n;
    logic        cfgreq;
    logic        cfgweb;
    logic [1:0]  cfgad;
    logic [31:0] cfgd;
    logic        cfgack;
    logic [31:0] cfgq;
    logic        fll_lock;
    logic [15:0] dco_cnt;
    logic        mode;
    logic        lock_en;
    logic [3:0]  loop_gain;
    logic [9:0]  dco_in;
    logic [15:0] mul_factor;
    logic [3:0]  lock_tol;
    logic [7:0]  lock_cnt;
    logic [3:0]  unlock_cnt;
    logic [31:0] integ_val;
    logic        cfg_update;
    logic        integ_load;

    int   errors = 0;
    int   checks = 0;
    int   ack_rises = 0;
    exp_t exp_q[$];

    fll_cfg_slave dut (
        .ref_clk(ref_clk), .rst_n(rst_n),
        .cfgreq(cfgreq), .cfgweb(cfgweb), .cfgad(cfgad), .cfgd(cfgd),
        .cfgack(cfgack), .cfgq(cfgq),
        .fll_lock(fll_lock), .dco_cnt(dco_cnt),
        .mode(mode), .lock_en(lock_en), .loop_gain(loop_gain),
        .dco_in(dco_in), .mul_factor(mul_factor),
        .lock_tol(lock_tol), .lock_cnt(lock_cnt), .unlock_cnt(unlock_cnt),
        .integ_val(integ_val), .cfg_update(cfg_update), .integ_load(integ_load)
    );

    initial begin
        ref_clk = 1'b0;
        forever #5 ref_clk = ~ref_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cfg1_out();
        return {mode, lock_en, loop_gain, dco_in, mul_factor};
    endfunction

    function automatic logic [31:0] cfg2_out();
        return {16'h0, lock_tol, lock_cnt, unlock_cnt};
    endfunction

    // Monitor: compare on every cfgack rise, then confirm the strobes were single-cycle
    initial begin
        logic ack_prev;
        logic pulse_pend;
        exp_t e;
        ack_prev   = 1'b0;
        pulse_pend = 1'b0;
        forever begin
            @(negedge ref_clk);
            if (pulse_pend) begin
                chk("pulse_width", {30'h0, cfg_update, integ_load}, 32'h0);
                pulse_pend = 1'b0;
            end
            if (cfgack && !ack_prev) begin
                ack_rises++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("cfgq", cfgq, e.q);
                    chk("cfg1_out", cfg1_out(), e.cfg1);
                    chk("cfg2_out", cfg2_out(), {16'h0, e.cfg2});
                    chk("integ_val", integ_val, e.integ);
                    chk("pulses", {30'h0, cfg_update, integ_load}, {30'h0, e.pulses});
                    pulse_pend = 1'b1;
                end
                $display("ack #%0d: cfgq=%h cfg1=%h cfg2=%h integ=%h upd=%b load=%b",
                         ack_rises, cfgq, cfg1_out(), cfg2_out(), integ_val, cfg_update, integ_load);
            end
            ack_prev = cfgack;
        end
    end

    // One 4-phase access: raise req, time the ack, optionally hold, then release or reset
    task automatic access(input logic web, input logic [1:0] ad, input logic [31:0] d,
                          input int hold, input bit rst_in_ack, input exp_t e);
        int  n;
        bit  stayed;
        int  rises0;
        exp_q.push_back(e);
        @(posedge ref_clk); #1;
        cfgreq = 1'b1; cfgweb = web; cfgad = ad; cfgd = d;
        rises0 = ack_rises;
        n = 0;
        while (!cfgack && n < 20) begin
            @(posedge ref_clk); #1;
            n++;
        end
        chk("ack_latency", n, LAT);
        // Bus fields change outside ACCESS; must not disturb anything
        cfgweb = ~web; cfgad = ~ad; cfgd = ~d;
        stayed = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge ref_clk); #1;
            if (!cfgack) stayed = 1'b0;
        end
        if (hold > 0) begin
            chk("ack_held", {31'h0, stayed}, 32'h1);
            chk("single_access", ack_rises - rises0, 1);
        end
        if (rst_in_ack) begin
            rst_n = 1'b0; cfgreq = 1'b0;
            @(posedge ref_clk); #1;
            chk("rst_ack_low", {31'h0, cfgack}, 32'h0);
            chk("rst_integ", integ_val, 32'h0);
            chk("rst_cfg1", cfg1_out(), 32'h4088_0001);
            rst_n = 1'b1;
        end else begin
            cfgreq = 1'b0;
            n = 0;
            while (cfgack && n < 20) begin
                @(posedge ref_clk); #1;
                n++;
            end
            chk("release_latency", n, REL);
        end
        $display("access web=%b ad=%0d d=%h: ack after %0d edges", web, ad, d, LAT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfgreq = 1'b0; cfgweb = 1'b1; cfgad = 2'd0; cfgd = 32'h0;
        fll_lock = 1'b0; dco_cnt = 16'h0;
        repeat (2) @(posedge ref_clk);
        #1;
        // Reset state
        chk("reset_ack", {31'h0, cfgack}, 32'h0);
        chk("reset_mul", {16'h0, mul_factor}, 32'h0001);
        chk("reset_lock_en", {31'h0, lock_en}, 32'h1);
        chk("reset_dco_in", {22'h0, dco_in}, 32'h088);
        chk("reset_integ", integ_val, 32'h0);
        chk("reset_cfgq", cfgq, 32'h0);
        chk("reset_cfg2", cfg2_out(), 32'h0F20);
        chk("reset_pulses", {30'h0, cfg_update, integ_load}, 32'h0);
        $display("reset: ack=%b cfg1=%h cfg2=%h integ=%h", cfgack, cfg1_out(), cfg2_out(), integ_val);
        rst_n = 1'b1;

        //      web   ad    d              hold rst  {q,           cfg1,          cfg2,     integ,         pulses}
        access(1'b0, 2'd1, 32'hC088_0010, 0, 1'b0, '{32'h0000_0000, 32'hC088_0010, 16'h0F20, 32'h0000_0000, 2'b10});
        fll_lock = 1'b1; dco_cnt = 16'h1234;
        access(1'b1, 2'd0, 32'h0,         0, 1'b0, '{32'h8000_1234, 32'hC088_0010, 16'h0F20, 32'h0000_0000, 2'b00});
        access(1'b0, 2'd0, 32'hFFFF_FFFF, 0, 1'b0, '{32'h8000_1234, 32'hC088_0010, 16'h0F20, 32'h0000_0000, 2'b00});
        fll_lock = 1'b0; dco_cnt = 16'hBEEF;
        access(1'b1, 2'd0, 32'h0,         0, 1'b0, '{32'h0000_BEEF, 32'hC088_0010, 16'h0F20, 32'h0000_0000, 2'b00});
        access(1'b0, 2'd2, 32'hDEAD_5A73, 0, 1'b0, '{32'h0000_BEEF, 32'hC088_0010, 16'h5A73, 32'h0000_0000, 2'b10});
        access(1'b1, 2'd2, 32'h0,         0, 1'b0, '{32'h0000_5A73, 32'hC088_0010, 16'h5A73, 32'h0000_0000, 2'b00});
        access(1'b1, 2'd1, 32'h0,         0, 1'b0, '{32'hC088_0010, 32'hC088_0010, 16'h5A73, 32'h0000_0000, 2'b00});
        access(1'b0, 2'd3, 32'h0000_ABCD, 0, 1'b1, '{32'hC088_0010, 32'hC088_0010, 16'h5A73, 32'h0000_ABCD, 2'b01});

        // Reset while in ACCESS: the pending CFG2 write must be lost
        @(posedge ref_clk); #1;
        cfgreq = 1'b1; cfgweb = 1'b0; cfgad = 2'd2; cfgd = 32'h1111_2222;
        repeat (LAT - 1) @(posedge ref_clk);
        #1;
        rst_n = 1'b0;
        @(posedge ref_clk); #1;
        chk("midrst_ack", {31'h0, cfgack}, 32'h0);
        chk("midrst_cfg2", cfg2_out(), 32'h0F20);
        chk("midrst_update", {31'h0, cfg_update}, 32'h0);
        $display("reset in ACCESS: ack=%b cfg2=%h", cfgack, cfg2_out());
        cfgreq = 1'b0;
        @(posedge ref_clk); #1;
        rst_n = 1'b1;

        access(1'b1, 2'd2, 32'h0,         0,  1'b0, '{32'h0000_0F20, 32'h4088_0001, 16'h0F20, 32'h0000_0000, 2'b00});
        access(1'b1, 2'd1, 32'h0,         10, 1'b0, '{32'h4088_0001, 32'h4088_0001, 16'h0F20, 32'h0000_0000, 2'b00});
        access(1'b1, 2'd3, 32'h0,         0,  1'b0, '{32'h0000_0000, 32'h4088_0001, 16'h0F20, 32'h0000_0000, 2'b00});

        repeat (4) @(posedge ref_clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
